// File: rtl/tmds_pattern_gen.sv
// Multi-lane TMDS test-symbol source: PRBS, clock, ramp and fixed patterns, continuous or burst.
// Optional one-shot lane-0 bit-0 error injection when TMDS_PATTERN_ERR_INJECT_EN is defined.
module tmds_pattern_gen #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned SYMBOL_WIDTH = 10,
  parameter logic [SYMBOL_WIDTH-1:0] LFSR_TAPS = 10'h240,
  parameter logic [SYMBOL_WIDTH-1:0] LFSR_SEED = 10'h3FF,
  parameter int unsigned BURST_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic [1:0]                       mode_i,
  input  logic [BURST_WIDTH-1:0]           burst_len_i,
  input  logic [SYMBOL_WIDTH-1:0]          fixed_symbol_i,
  input  logic [CHANNELS-1:0]              fifo_full_i,
`ifdef TMDS_PATTERN_ERR_INJECT_EN
  input  logic                             inject_i,
  output logic [15:0]                      inject_count_o,
`endif
  output logic                             write_o,
  output logic [CHANNELS*SYMBOL_WIDTH-1:0] symbols_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [COUNT_WIDTH-1:0]           sym_count_o
);

  localparam int unsigned W = SYMBOL_WIDTH;
  localparam logic [W-1:0] ClkSym = W'((1 << (W / 2)) - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;
  typedef enum logic [1:0] {ModePrbs, ModeClock, ModeRamp, ModeFixed} mode_e;

  state_e                    state_q;
  mode_e                     mode_q;
  logic                      busy_q, done_q, continuous_q;
  logic [BURST_WIDTH-1:0]    remaining_q;
  logic [COUNT_WIDTH-1:0]    sym_count_q;
  logic [CHANNELS*W-1:0]     gen_q, gen_load, gen_adv;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int unsigned n);
    int unsigned k;
    k = n % W;
    return (v << k) | (v >> (W - k));
  endfunction

  always_comb begin
    gen_load = '0;
    gen_adv  = gen_q;
    for (int c = 0; c < CHANNELS; c++) begin
      unique case (mode_e'(mode_i))
        ModePrbs:  gen_load[c*W +: W] = rotl(LFSR_SEED, c);
        ModeClock: gen_load[c*W +: W] = ClkSym;
        ModeRamp:  gen_load[c*W +: W] = W'(c);
        ModeFixed: gen_load[c*W +: W] = fixed_symbol_i;
      endcase
      unique case (mode_q)
        ModePrbs: gen_adv[c*W +: W] = {gen_q[c*W +: W-1], ^(gen_q[c*W +: W] & LFSR_TAPS)};
        ModeRamp: gen_adv[c*W +: W] = gen_q[c*W +: W] + W'(1);
        default:  gen_adv[c*W +: W] = gen_q[c*W +: W];
      endcase
    end
  end

  // One full lane stalls every lane so the lanes never drift apart.
  assign write_o = busy_q & ~stop_i & ~|fifo_full_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      mode_q       <= ModePrbs;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      continuous_q <= 1'b0;
      remaining_q  <= '0;
      sym_count_q  <= '0;
      gen_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && !stop_i) begin
            state_q      <= StRun;
            busy_q       <= 1'b1;
            mode_q       <= mode_e'(mode_i);
            remaining_q  <= burst_len_i;
            continuous_q <= (burst_len_i == '0);
            sym_count_q  <= '0;
            gen_q        <= gen_load;
          end
        end
        StRun: begin
          if (stop_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (write_o) begin
            gen_q       <= gen_adv;
            sym_count_q <= sym_count_q + COUNT_WIDTH'(1);
            remaining_q <= remaining_q - BURST_WIDTH'(1);
            if (!continuous_q && remaining_q == BURST_WIDTH'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sym_count_o = sym_count_q;

`ifdef TMDS_PATTERN_ERR_INJECT_EN
  logic        inj_armed_q;
  logic [15:0] inj_count_q;

  // Corruption is applied on the output only, so the generators stay clean.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      inj_armed_q <= 1'b0;
      inj_count_q <= '0;
    end else begin
      inj_armed_q <= inject_i | (inj_armed_q & ~write_o);
      if (inj_armed_q && write_o && inj_count_q != 16'hFFFF) begin
        inj_count_q <= inj_count_q + 16'd1;
      end
    end
  end

  assign symbols_o      = gen_q ^ {{(CHANNELS*W-1){1'b0}}, inj_armed_q & busy_q};
  assign inject_count_o = inj_count_q;
`else
  assign symbols_o = gen_q;
`endif

endmodule

// File: tb/tb_tmds_pattern_gen.sv
// Directed, table-driven bench for tmds_pattern_gen (default 3 lanes x 10 bits).
module tb_tmds_pattern_gen;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0, stop_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [15:0] burst_len_i = '0;
  logic [9:0]  fixed_symbol_i = '0;
  logic [2:0]  fifo_full_i = '0;
  logic        write_o, busy_o, done_o;
  logic [29:0] symbols_o;
  logic [31:0] sym_count_o;
`ifdef TMDS_PATTERN_ERR_INJECT_EN
  logic        inject_i = 1'b0;
  logic [15:0] inject_count_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  tmds_pattern_gen dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .mode_i         (mode_i),
    .burst_len_i    (burst_len_i),
    .fixed_symbol_i (fixed_symbol_i),
    .fifo_full_i    (fifo_full_i),
`ifdef TMDS_PATTERN_ERR_INJECT_EN
    .inject_i       (inject_i),
    .inject_count_o (inject_count_o),
`endif
    .write_o        (write_o),
    .symbols_o      (symbols_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .sym_count_o    (sym_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
    #1;
  endtask

  // Returns in the first RUN cycle with start deasserted.
  task automatic do_start(input logic [1:0] m, input logic [15:0] bl, input logic [9:0] fx);
    @(negedge clk_i);
    start_i = 1'b1; mode_i = m; burst_len_i = bl; fixed_symbol_i = fx;
    @(negedge clk_i);
    start_i = 1'b0; mode_i = 2'd0; burst_len_i = 16'd0; fixed_symbol_i = 10'd0;
    #1;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    #1;
    chk("stop_write", {31'd0, write_o}, 32'd0);
    next_cycle();
    stop_i = 1'b0;
    #1;
    chk("stop_busy", {31'd0, busy_o}, 32'd0);
    chk("stop_done", {31'd0, done_o}, 32'd0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [9:0] fixed;
    logic [9:0] l0, l1, l2, l0_next;
  } vec_t;

  vec_t vecs[5];
  logic [9:0] prbs_exp[8];

  initial begin
    vecs[0] = '{mode: 2'd0, fixed: 10'h000, l0: 10'h3FF, l1: 10'h3FF, l2: 10'h3FF, l0_next: 10'h3FE};
    vecs[1] = '{mode: 2'd1, fixed: 10'h000, l0: 10'h01F, l1: 10'h01F, l2: 10'h01F, l0_next: 10'h01F};
    vecs[2] = '{mode: 2'd2, fixed: 10'h000, l0: 10'h000, l1: 10'h001, l2: 10'h002, l0_next: 10'h001};
    vecs[3] = '{mode: 2'd3, fixed: 10'h2AA, l0: 10'h2AA, l1: 10'h2AA, l2: 10'h2AA, l0_next: 10'h2AA};
    vecs[4] = '{mode: 2'd3, fixed: 10'h155, l0: 10'h155, l1: 10'h155, l2: 10'h155, l0_next: 10'h155};
    prbs_exp = '{10'h3FF, 10'h3FE, 10'h3FC, 10'h3F8, 10'h3F0, 10'h3E0, 10'h3C0, 10'h380};

    // Reset state
    #3;
    chk("rst_write", {31'd0, write_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_count", sym_count_o, 32'd0);
    chk("rst_symbols", {2'd0, symbols_o}, 32'd0);
    next_cycle();
    reset_n_i = 1'b1;
    next_cycle();

    // Per-mode load values and first advance
    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].mode, 16'd0, vecs[i].fixed);
      chk("vec_busy", {31'd0, busy_o}, 32'd1);
      chk("vec_write", {31'd0, write_o}, 32'd1);
      chk("vec_l0", {22'd0, symbols_o[9:0]}, {22'd0, vecs[i].l0});
      chk("vec_l1", {22'd0, symbols_o[19:10]}, {22'd0, vecs[i].l1});
      chk("vec_l2", {22'd0, symbols_o[29:20]}, {22'd0, vecs[i].l2});
      next_cycle();
      chk("vec_l0_next", {22'd0, symbols_o[9:0]}, {22'd0, vecs[i].l0_next});
      do_stop();
    end

    // PRBS continuous sequence
    do_start(2'd0, 16'd0, 10'd0);
    for (int i = 0; i < 8; i++) begin
      chk("prbs_write", {31'd0, write_o}, 32'd1);
      chk("prbs_l0", {22'd0, symbols_o[9:0]}, {22'd0, prbs_exp[i]});
      next_cycle();
    end
    chk("prbs_count", sym_count_o, 32'd8);
    do_stop();

    // RAMP burst of 4
    do_start(2'd2, 16'd4, 10'd0);
    for (int i = 0; i < 4; i++) begin
      chk("ramp_l0", {22'd0, symbols_o[9:0]}, i);
      chk("ramp_l2", {22'd0, symbols_o[29:20]}, i + 2);
      chk("ramp_done_early", {31'd0, done_o}, 32'd0);
      next_cycle();
    end
    chk("ramp_done", {31'd0, done_o}, 32'd1);
    chk("ramp_busy", {31'd0, busy_o}, 32'd0);
    chk("ramp_write", {31'd0, write_o}, 32'd0);
    chk("ramp_count", sym_count_o, 32'd4);
    next_cycle();
    chk("ramp_done_once", {31'd0, done_o}, 32'd0);

    // CLOCK burst of 3 with lane 1 full every other cycle
    fifo_full_i = 3'b010;
    do_start(2'd1, 16'd3, 10'd0);
    for (int c = 0; c < 6; c++) begin
      fifo_full_i = (c % 2 == 0) ? 3'b010 : 3'b000;
      #1;
      chk("clk_busy", {31'd0, busy_o}, 32'd1);
      chk("clk_write", {31'd0, write_o}, c % 2);
      chk("clk_syms", {2'd0, symbols_o}, {2'd0, {3{10'h01F}}});
      next_cycle();
    end
    fifo_full_i = 3'b000;
    #1;
    chk("clk_done", {31'd0, done_o}, 32'd1);
    chk("clk_busy_end", {31'd0, busy_o}, 32'd0);
    chk("clk_count", sym_count_o, 32'd3);

    // FIXED continuous, stopped after 10 writes
    do_start(2'd3, 16'd0, 10'h2AA);
    for (int i = 0; i < 10; i++) begin
      chk("fix_l0", {22'd0, symbols_o[9:0]}, 32'h2AA);
      next_cycle();
    end
    do_stop();
    chk("fix_count", sym_count_o, 32'd10);
    next_cycle();
    chk("fix_no_done", {31'd0, done_o}, 32'd0);
    chk("fix_count_hold", sym_count_o, 32'd10);

    // Start and stop together in IDLE
    start_i = 1'b1; stop_i = 1'b1;
    next_cycle();
    start_i = 1'b0; stop_i = 1'b0;
    #1;
    chk("ss_busy", {31'd0, busy_o}, 32'd0);
    chk("ss_write", {31'd0, write_o}, 32'd0);

    // Reset mid-run, then restart
    do_start(2'd0, 16'd0, 10'd0);
    next_cycle();
    next_cycle();
    reset_n_i = 1'b0;
    #1;
    chk("mrst_write", {31'd0, write_o}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_count", sym_count_o, 32'd0);
    chk("mrst_symbols", {2'd0, symbols_o}, 32'd0);
    next_cycle();
    reset_n_i = 1'b1;
    do_start(2'd0, 16'd0, 10'd0);
    chk("restart_l0", {22'd0, symbols_o[9:0]}, 32'h3FF);
    next_cycle();
    chk("restart_l0_next", {22'd0, symbols_o[9:0]}, 32'h3FE);
    do_stop();

`ifdef TMDS_PATTERN_ERR_INJECT_EN
    // Inject on the write that would carry 005
    do_start(2'd2, 16'd0, 10'd0);
    for (int i = 0; i < 4; i++) next_cycle();
    chk("inj_pre", {22'd0, symbols_o[9:0]}, 32'h004);
    inject_i = 1'b1;
    next_cycle();
    inject_i = 1'b0;
    chk("inj_sym", {22'd0, symbols_o[9:0]}, 32'h004);
    next_cycle();
    chk("inj_after", {22'd0, symbols_o[9:0]}, 32'h006);
    chk("inj_count", {16'd0, inject_count_o}, 32'd1);
    do_stop();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
